// File: rtl/dmem_line_responder.sv
// Memory-side responder for the data-cache line request bus.
// Accepts one 64-byte line read or write at a time, acknowledges it, waits a
// fixed latency, then completes with a single-cycle ddone pulse. Storage is a
// line-granular array indexed by daddr[6 +: IDX_W]. Higher address bits alias,
// and the byte offset bits are ignored.
module dmem_line_responder #(
  parameter int LINE_BITS = 512,
  parameter int IDX_W     = 10,
  parameter int LATENCY   = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 drequest,
  input  logic                 dwrenable,
  input  logic [63:0]          daddr,
  input  logic [LINE_BITS-1:0] dwdata,
  output logic                 dreqack,
  output logic [LINE_BITS-1:0] drdata,
  output logic                 ddone,
  output logic [31:0]          req_count
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  // The counter is loaded in the ack cycle, so it starts one below the latency.
  localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

  logic [LINE_BITS-1:0] mem [2**IDX_W];

  state_t               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic                 wen_q, wen_d;
  logic [LINE_BITS-1:0] wbuf_q, wbuf_d;
  logic                 dreqack_q, dreqack_d;
  logic                 ddone_q, ddone_d;
  logic [LINE_BITS-1:0] drdata_q, drdata_d;
  logic [31:0]          req_count_q, req_count_d;
  logic                 mem_we;

  // Byte-offset and aliased upper address bits carry no meaning here.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{daddr[63:6+IDX_W], daddr[5:0]};

  // Next-state, request capture, and completion logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    wen_d       = wen_q;
    wbuf_d      = wbuf_q;
    dreqack_d   = 1'b0;
    ddone_d     = 1'b0;
    drdata_d    = '0;
    req_count_d = req_count_q;
    mem_we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (drequest) begin
          idx_d       = daddr[6 +: IDX_W];
          wen_d       = dwrenable;
          wbuf_d      = dwdata;
          dreqack_d   = 1'b1;
          cnt_d       = LAT_M1;
          req_count_d = req_count_q + 32'd1;
          state_d     = BUSY;
        end
      end
      BUSY: begin
        // drequest is deliberately ignored; the initiator may still hold it.
        if (cnt_q == 8'd0) begin
          state_d = DONE;
          ddone_d = 1'b1;
          if (wen_q) mem_we   = 1'b1;
          else       drdata_d = mem[idx_q];
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state and registered outputs; reset drops any in-flight request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      dreqack_q   <= 1'b0;
      ddone_q     <= 1'b0;
      drdata_q    <= '0;
      req_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dreqack_q   <= dreqack_d;
      ddone_q     <= ddone_d;
      drdata_q    <= drdata_d;
      req_count_q <= req_count_d;
    end
  end

  // Captured request fields; meaningful only while a request is in flight.
  always_ff @(posedge clk) begin
    idx_q  <= idx_d;
    wen_q  <= wen_d;
    wbuf_q <= wbuf_d;
  end

  // Line write commits on the edge that raises ddone, unless reset cancels it.
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem[idx_q] <= wbuf_q;
  end

  assign dreqack   = dreqack_q;
  assign ddone     = ddone_q;
  assign drdata    = drdata_q;
  assign req_count = req_count_q;

endmodule

// File: tb/tb_dmem_line_responder.sv
// Directed testbench for dmem_line_responder (LATENCY = 4, IDX_W = 10).
module tb_dmem_line_responder;

  localparam int LB  = 512;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          drequest = 1'b0;
  logic          dwrenable = 1'b0;
  logic [63:0]   daddr = '0;
  logic [LB-1:0] dwdata = '0;
  logic          dreqack;
  logic [LB-1:0] drdata;
  logic          ddone;
  logic [31:0]   req_count;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  dmem_line_responder #(.LINE_BITS(LB), .IDX_W(10), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .drequest(drequest), .dwrenable(dwrenable),
    .daddr(daddr), .dwdata(dwdata), .dreqack(dreqack), .drdata(drdata),
    .ddone(ddone), .req_count(req_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [LB-1:0] got, input logic [LB-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic reset_dut();
    reset    = 1'b1;
    drequest = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Issue one request from a negedge and follow it to ddone (bounded).
  task automatic do_req(input logic wr, input logic [63:0] addr, input logic [LB-1:0] wd,
                        input int hold_extra, output int t_req, output int t_ack,
                        output int t_done, output logic [LB-1:0] rd,
                        output int n_ack, output int n_done);
    t_req = cyc; t_ack = -1; t_done = -1; rd = '0; n_ack = 0; n_done = 0;
    dwrenable = wr; daddr = addr; dwdata = wd; drequest = 1'b1;
    for (int i = 0; i < 40 && t_done < 0; i++) begin
      @(negedge clk);
      if (dreqack) begin n_ack++; if (t_ack < 0) t_ack = cyc; end
      if (ddone) begin n_done++; t_done = cyc; rd = drdata; end
      if (t_ack >= 0 && (cyc - t_ack) >= hold_extra) drequest = 1'b0;
    end
    drequest = 1'b0;
    if (t_done < 0) check("ddone_timeout", 512'(0), 512'(1));
  endtask

  logic [LB-1:0] pa5, pp, pq, pr, ps, rd;
  int tr, ta, td, na, nd, td1, tr2, ta2, td2;
  logic got_ack;

  initial begin
    pa5 = {64{8'hA5}};
    pp  = {16{32'hDEADBEEF}};
    pq  = {8{64'h0123456789ABCDEF}};
    pr  = {32{16'h7E57}};
    ps  = {64{8'h5A}};

    // Reset state
    reset_dut();
    check("rst_dreqack", 512'(dreqack), 512'(0));
    check("rst_ddone", 512'(ddone), 512'(0));
    check("rst_drdata", drdata, '0);
    check("rst_req_count", 512'(req_count), 512'(0));

    // Preload idx 5 with A5..A5, then read it back with exact timing
    do_req(1'b1, 64'(5 << 6), pa5, 0, tr, ta, td, rd, na, nd);
    check("wr5_ack_lat", 512'(ta - tr), 512'(1));
    check("wr5_done_lat", 512'(td - tr), 512'(LAT + 1));
    check("wr5_drdata_zero", rd, '0);
    check("wr5_req_count", 512'(req_count), 512'(1));
    @(negedge clk);
    do_req(1'b0, 64'(5 << 6), '0, 0, tr, ta, td, rd, na, nd);
    check("rd5_ack_lat", 512'(ta - tr), 512'(1));
    check("rd5_done_lat", 512'(td - tr), 512'(LAT + 1));
    check("rd5_data", rd, pa5);
    @(negedge clk);
    check("rd5_drdata_clear", drdata, '0);
    check("rd5_ddone_clear", 512'(ddone), 512'(0));
    check("rd5_req_count", 512'(req_count), 512'(2));

    // Write 0x1000 then read it back
    do_req(1'b1, 64'h1000, pp, 0, tr, ta, td, rd, na, nd);
    check("wr1000_done", 512'(nd), 512'(1));
    @(negedge clk);
    do_req(1'b0, 64'h1000, '0, 0, tr, ta, td, rd, na, nd);
    check("rd1000_done", 512'(nd), 512'(1));
    check("rd1000_data", rd, pp);

    // Cache read-modify-write: write issued in the read's ddone cycle
    reset_dut();
    do_req(1'b0, 64'h40, '0, 0, tr, ta, td1, rd, na, nd);
    do_req(1'b1, 64'h40, pq, 0, tr2, ta2, td2, rd, na, nd);
    check("rmw_ack_gap", 512'(ta2 - td1), 512'(2));
    check("rmw_done_gap", 512'(td2 - td1), 512'(LAT + 2));
    check("rmw_req_count", 512'(req_count), 512'(2));
    @(negedge clk);
    do_req(1'b0, 64'h40, '0, 0, tr, ta, td, rd, na, nd);
    check("rmw_readback", rd, pq);

    // Aliasing: upper index bits and byte offset are ignored
    do_req(1'b1, 64'h0, pq ^ pp, 0, tr, ta, td, rd, na, nd);
    @(negedge clk);
    do_req(1'b0, 64'h10000, '0, 0, tr, ta, td, rd, na, nd);
    check("alias_upper", rd, pq ^ pp);
    @(negedge clk);
    do_req(1'b0, 64'h3F, '0, 0, tr, ta, td, rd, na, nd);
    check("alias_offset", rd, pq ^ pp);

    // Reset during BUSY of a write to idx 7 cancels it
    reset_dut();
    do_req(1'b1, 64'(7 << 6), pr, 0, tr, ta, td, rd, na, nd);
    @(negedge clk);
    dwrenable = 1'b1; daddr = 64'(7 << 6); dwdata = ps; drequest = 1'b1;
    got_ack = 1'b0;
    for (int i = 0; i < 10 && !got_ack; i++) begin
      @(negedge clk);
      if (dreqack) got_ack = 1'b1;
    end
    drequest = 1'b0;
    check("abort_ack", 512'(got_ack), 512'(1));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_dreqack", 512'(dreqack), 512'(0));
    check("abort_ddone", 512'(ddone), 512'(0));
    check("abort_drdata", drdata, '0);
    check("abort_req_count", 512'(req_count), 512'(0));
    nd = 0;
    repeat (8) begin
      @(negedge clk);
      if (ddone || dreqack) nd++;
    end
    check("abort_no_pulses", 512'(nd), 512'(0));
    do_req(1'b0, 64'(7 << 6), '0, 0, tr, ta, td, rd, na, nd);
    check("abort_mem_kept", rd, pr);
    check("abort_next_ack_lat", 512'(ta - tr), 512'(1));
    check("abort_next_req_count", 512'(req_count), 512'(1));

    // drequest held one cycle past ack
    reset_dut();
    do_req(1'b0, 64'(5 << 6), '0, 1, tr, ta, td, rd, na, nd);
    repeat (6) begin
      @(negedge clk);
      if (dreqack) na++;
      if (ddone) nd++;
    end
    check("hold_n_ack", 512'(na), 512'(1));
    check("hold_n_done", 512'(nd), 512'(1));
    check("hold_req_count", 512'(req_count), 512'(1));
    check("hold_data", rd, pa5);

    // Reset and drequest together: reset wins
    dwrenable = 1'b0; daddr = 64'(5 << 6); drequest = 1'b1; reset = 1'b1;
    @(negedge clk);
    drequest = 1'b0; reset = 1'b0;
    check("rstreq_req_count", 512'(req_count), 512'(0));
    na = 0;
    repeat (LAT + 3) begin
      @(negedge clk);
      if (dreqack || ddone) na++;
    end
    check("rstreq_no_pulses", 512'(na), 512'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
